serial_mul_ctrl: RTL

Sequencing controller for the bit-serial multiplier datapath. It accepts parallel N-bit operands over a valid/ready handshake, clears the datapath, and streams the multiplicand LSB-first for 2N cycles, with zeros for the upper N cycles to flush carries. It assembles the serial product bits into a 2N-bit result and holds that result on a valid/ready output port. It sits between the register-file/bus side of the design and the serial multiply datapath.

---
 rtl/serial_mul_pkg.sv | 29 ++
 rtl/serial_mul_ctrl_if.sv | 32 +++
 rtl/serial_mul_core.sv | 52 +++++
 rtl/serial_mul_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/serial_mul_pkg.sv
// rtl/serial_mul_pkg.sv - shared constants, state encoding and width helpers for the serial multiplier
// Contents:
//   N_DEF      default operand width
//   state_e    controller state encoding (IDLE/RUN/DONE)
//   cnt_w()    bit counter width for a 2N-cycle run
//   carry_w()  column carry register width
package serial_mul_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

  // ceil(log2(N)); kept at least one bit so tiny N still elaborates.
  function automatic int carry_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEF   = cnt_w(N_DEF);
  localparam int CARRY_W_DEF = carry_w(N_DEF);

endpackage

// File: rtl/serial_mul_ctrl_if.sv
// rtl/serial_mul_ctrl_if.sv - operand/product handshake bundle for serial_mul_ctrl
// Signals:
//   in_valid/in_ready/in_a/in_b   operand pair handshake (master -> controller)
//   out_valid/out_ready/out_prod  product handshake (controller -> master)
//   busy                          controller is running a multiply
// Modports: master = bus/register side, slave = controller.
interface serial_mul_ctrl_if
  import serial_mul_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_prod;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );

endinterface

// File: rtl/serial_mul_core.sv
// rtl/serial_mul_core.sv - bit-serial multiply datapath: s-bit history, AND/popcount column, carry
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   clr           clear history and carry (start of a new product)
//   en            advance one column
//   s_bit         serial multiplicand bit for this column
//   b             parallel multiplier, held for the whole run
//   p_bit         product bit for this column (combinational)
// Requires N >= 2.
module serial_mul_core
  import serial_mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         s_bit,
  input  logic [N-1:0] b,
  output logic         p_bit
);

  localparam int CW = carry_w(N);
  localparam int SW = CW + 1;

  // hist_q[j-1] holds s_{k-j}: the multiplicand bits seen j columns ago.
  logic [N-2:0]  hist_q;
  logic [CW-1:0] carry_q;
  logic [SW-1:0] column;

  always_comb begin
    column = SW'(carry_q);
    column = column + SW'(b[0] & s_bit);
    for (int j = 1; j < N; j++) begin
      column = column + SW'(b[j] & hist_q[j-1]);
    end
  end

  assign p_bit = column[0];

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      hist_q  <= '0;
      carry_q <= '0;
    end else if (en) begin
      carry_q <= column[SW-1:1];
      hist_q  <= (hist_q << 1) | (N-1)'(s_bit);
    end
  end

endmodule

// File: rtl/serial_mul_ctrl.sv
// rtl/serial_mul_ctrl.sv - sequencing controller for the bit-serial multiplier
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus           serial_mul_ctrl_if.slave: operand and product handshakes, busy
// Accepts operands, runs 2N serial columns (multiplicand LSB-first, then N
// zero columns to flush the carry), and holds the 2N-bit product until taken.
module serial_mul_ctrl
  import serial_mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                clock,
  input  logic                reset,
  serial_mul_ctrl_if.slave    bus
);

  localparam int              CNTW = cnt_w(N);
  localparam logic [CNTW-1:0] LAST = CNTW'(2 * N - 1);

  state_e           state_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2*N-1:0]   p_q;
  logic [CNTW-1:0]  cnt_q;
  logic             out_valid_q;
  logic             busy_q;

  logic in_ready;
  logic accept;
  logic s_bit;
  logic p_bit;
  logic core_en;

  // Combinational from out_ready so a DONE->RUN hand-over costs no bubble.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign core_en  = (state_q == RUN);
  // Upper N columns feed zeros so the remaining carry drains into P.
  assign s_bit    = (cnt_q < CNTW'(N)) ? a_q[0] : 1'b0;

  serial_mul_core #(.N(N)) u_core (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (core_en),
    .s_bit (s_bit),
    .b     (b_q),
    .p_bit (p_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // Reachable from IDLE, or from DONE while the product is being taken.
      state_q     <= RUN;
      a_q         <= bus.in_a;
      b_q         <= bus.in_b;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          a_q   <= a_q >> 1;
          p_q   <= {p_bit, p_q[2*N-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = p_q;
  assign bus.busy      = busy_q;

endmodule
